banyan_dst_gen: RTL and testbench

- Feeder for the packer's banyan router.
- Takes sparse N-lane beats with per-lane keep bits and computes each kept lane's destination lane index.
- Destinations are the running compaction offset plus the lane's prefix count of kept lanes, modulo N. Kept lanes therefore land in consecutive cyclic output positions across beats.
- Drives the router's din/dst_in/in_vld through one registered, backpressure-capable stage, and tracks word-completion status.

---
 rtl/banyan_pkg.sv | 23 ++
 rtl/banyan_prefix_cnt.sv | 30 +++
 rtl/banyan_dst_gen.sv | 110 +++++++++++
 tb/tb_banyan_dst_gen.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/banyan_pkg.sv
// Shared types and helpers for the banyan destination generator.
// Default lane geometry plus a generic popcount used by the prefix logic.
package banyan_pkg;

  localparam int unsigned BANYAN_N    = 4;
  localparam int unsigned BANYAN_LOGN = $clog2(BANYAN_N);
  localparam int unsigned POP_W       = 64;

  typedef logic [BANYAN_LOGN-1:0] lane_idx_t;
  typedef logic [BANYAN_LOGN:0]   lane_cnt_t;

  function automatic int unsigned popcount(
    input logic [POP_W-1:0] v
  );
    int unsigned r;
    r = 0;
    for (int i = 0; i < POP_W; i++) begin
      r = r + 32'(v[i]);
    end
    return r;
  endfunction

endpackage

// File: rtl/banyan_prefix_cnt.sv
// Exclusive prefix popcount of the keep mask, plus the beat total.
// pre_o[i] counts kept lanes strictly below lane i.
module banyan_prefix_cnt
  import banyan_pkg::*;
#(
  parameter  int unsigned N    = 4,
  localparam int unsigned LOGN = $clog2(N)
) (
  input  logic [N-1:0]         keep_i,
  output logic [N-1:0][LOGN:0] pre_o,
  output logic [LOGN:0]        cnt_o
);

  logic [POP_W-1:0] masked;

  // Per-lane masked popcount of the lower lanes, then the full total
  always_comb begin
    masked = '0;
    pre_o  = '0;
    for (int i = 0; i < N; i++) begin
      masked = '0;
      for (int j = 0; j < i; j++) begin
        masked[j] = keep_i[j];
      end
      pre_o[i] = (LOGN+1)'(popcount(masked));
    end
    cnt_o = (LOGN+1)'(popcount(POP_W'(keep_i)));
  end

endmodule

// File: rtl/banyan_dst_gen.sv
// Banyan router feeder: per-lane compaction destinations, one output stage.
// BANYAN_DST_GEN_DROP_EMPTY_EN: swallow empty non-last beats.
module banyan_dst_gen
  import banyan_pkg::*;
#(
  parameter  int unsigned N      = 4,
  parameter  int unsigned DWIDTH = 8,
  localparam int unsigned LOGN   = $clog2(N)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N-1:0][DWIDTH-1:0]   s_data,
  input  logic [N-1:0]               s_keep,
  input  logic                       s_last,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [N-1:0][DWIDTH-1:0]   m_data,
  output logic [N-1:0][LOGN-1:0]     m_dst,
  output logic [N-1:0]               m_vld,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       m_wrap,
  output logic                       m_last,
  output logic                       m_partial,
  output logic [LOGN-1:0]            m_fill
);

  logic [N-1:0][LOGN:0]        pre;
  logic [LOGN:0]               cnt;
  logic [LOGN:0]               sum;
  logic [LOGN-1:0]             off_q;
  logic [N-1:0][LOGN-1:0]      dst_d;
  logic                        accept;
  logic                        load;

  logic [N-1:0][DWIDTH-1:0]    data_q;
  logic [N-1:0][LOGN-1:0]      dst_q;
  logic [N-1:0]                vld_q;
  logic                        valid_q;
  logic                        wrap_q;
  logic                        last_q;
  logic                        partial_q;
  logic [LOGN-1:0]             fill_q;

  banyan_prefix_cnt #(
    .N (N)
  ) u_prefix (
    .keep_i (s_keep),
    .pre_o  (pre),
    .cnt_o  (cnt)
  );

  assign s_ready = !valid_q || m_ready;
  assign accept  = s_valid && s_ready;

`ifdef BANYAN_DST_GEN_DROP_EMPTY_EN
  assign load = accept && (s_last || (s_keep != '0));
`else
  assign load = accept;
`endif

  assign sum = {1'b0, off_q} + cnt;

  // Kept lanes go to offset + prefix, wrapping within the word
  always_comb begin
    dst_d = '0;
    for (int i = 0; i < N; i++) begin
      if (s_keep[i]) begin
        dst_d[i] = LOGN'({1'b0, off_q} + pre[i]);
      end
    end
  end

  // Output stage and running offset; held while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      dst_q     <= '0;
      vld_q     <= '0;
      wrap_q    <= 1'b0;
      last_q    <= 1'b0;
      partial_q <= 1'b0;
      fill_q    <= '0;
      off_q     <= '0;
    end else if (load) begin
      valid_q   <= 1'b1;
      data_q    <= s_data;
      dst_q     <= dst_d;
      vld_q     <= s_keep;
      wrap_q    <= sum[LOGN];
      last_q    <= s_last;
      partial_q <= s_last && (sum[LOGN-1:0] != '0);
      fill_q    <= sum[LOGN-1:0];
      off_q     <= s_last ? '0 : sum[LOGN-1:0];
    end else if (m_ready) begin
      valid_q   <= 1'b0;
    end
  end

  assign m_valid   = valid_q;
  assign m_data    = data_q;
  assign m_dst     = dst_q;
  assign m_vld     = vld_q;
  assign m_wrap    = wrap_q;
  assign m_last    = last_q;
  assign m_partial = partial_q;
  assign m_fill    = fill_q;

endmodule

// File: tb/tb_banyan_dst_gen.sv
// Scoreboard bench for banyan_dst_gen (N=4, DWIDTH=8).
// Expected beats are modelled at accept and compared on output transfer.
module tb_banyan_dst_gen;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int LG = 2;

  typedef struct {
    logic [N*DW-1:0] data;
    logic [N*LG-1:0] dst;
    logic [N-1:0]    vld;
    logic            wrap;
    logic            last;
    logic            partial;
    logic [LG-1:0]   fill;
  } exp_t;

  logic                  clk;
  logic                  rst_n;
  logic [N-1:0][DW-1:0]  s_data;
  logic [N-1:0]          s_keep;
  logic                  s_last;
  logic                  s_valid;
  logic                  s_ready;
  logic [N-1:0][DW-1:0]  m_data;
  logic [N-1:0][LG-1:0]  m_dst;
  logic [N-1:0]          m_vld;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_wrap;
  logic                  m_last;
  logic                  m_partial;
  logic [LG-1:0]         m_fill;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   off_m    = 0;

  banyan_dst_gen #(
    .N      (N),
    .DWIDTH (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data    (s_data),
    .s_keep    (s_keep),
    .s_last    (s_last),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .m_data    (m_data),
    .m_dst     (m_dst),
    .m_vld     (m_vld),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_wrap    (m_wrap),
    .m_last    (m_last),
    .m_partial (m_partial),
    .m_fill    (m_fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] keep,
                                 input logic last,
                                 input logic [N*DW-1:0] data,
                                 input int off);
    exp_t e;
    int   k;
    int   s;
    e.data = data;
    e.dst  = '0;
    e.vld  = keep;
    k = 0;
    for (int i = 0; i < N; i++) begin
      if (keep[i]) begin
        e.dst[i*LG +: LG] = LG'((off + k) % N);
        k++;
      end
    end
    s = off + k;
    e.wrap    = (s >= N);
    e.fill    = LG'(s % N);
    e.last    = last;
    e.partial = last && ((s % N) != 0);
    return e;
  endfunction

  task automatic send(input logic [N-1:0] keep,
                      input logic last,
                      input logic [N*DW-1:0] data);
    exp_t e;
    int   n;
    s_keep  = keep;
    s_last  = last;
    s_data  = data;
    s_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      n++;
      if (n > 20) begin
        chk("send_timeout", 64'(n), 64'd0);
        break;
      end
    end
    if (s_ready) begin
      e = model(keep, last, data, off_m);
`ifdef BANYAN_DST_GEN_DROP_EMPTY_EN
      if (keep != '0 || last) begin
        sb.push_back(e);
        off_m = last ? 0 : int'(e.fill);
      end
`else
      sb.push_back(e);
      off_m = last ? 0 : int'(e.fill);
`endif
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        chk("data",    64'(m_data),    64'(e.data));
        chk("dst",     64'(m_dst),     64'(e.dst));
        chk("vld",     64'(m_vld),     64'(e.vld));
        chk("wrap",    64'(m_wrap),    64'(e.wrap));
        chk("last",    64'(m_last),    64'(e.last));
        chk("partial", 64'(m_partial), 64'(e.partial));
        chk("fill",    64'(m_fill),    64'(e.fill));
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    s_data  = '0;
    s_keep  = '0;
    s_last  = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    #1;
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_dst",   64'(m_dst),   64'd0);
    chk("rst_data",  64'(m_data),  64'd0);
    chk("rst_flags", 64'({m_vld, m_wrap, m_last, m_partial}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_valid", 64'(m_valid), 64'd0);
    chk("idle_ready", 64'(s_ready), 64'd1);
    chk("idle_fill",  64'(m_fill),  64'd0);
    @(posedge clk);
    #1;

    send(4'b1111, 1'b0, 32'h44332211);
    send(4'b1111, 1'b0, 32'h88776655);
    send(4'b0101, 1'b0, 32'hA0B0C0D0);
    send(4'b1011, 1'b0, 32'h01020304);
    send(4'b0011, 1'b1, 32'hDEADBEEF);
    send(4'b0001, 1'b0, 32'h000000AA);
    send(4'b0000, 1'b0, 32'h12345678);
    send(4'b0000, 1'b1, 32'h9ABCDEF0);
    send(4'b0001, 1'b0, 32'h000000BB);

    @(posedge clk);
    #1;
    m_ready = 1'b0;
    send(4'b1111, 1'b0, 32'hCAFEF00D);
    s_keep  = 4'b0011;
    s_last  = 1'b0;
    s_data  = 32'h0000BEEF;
    s_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("hold_ready", 64'(s_ready), 64'd0);
      chk("hold_valid", 64'(m_valid), 64'd1);
      chk("hold_data",  64'(m_data),  64'(sb[0].data));
      chk("hold_dst",   64'(m_dst),   64'(sb[0].dst));
      chk("hold_fill",  64'(m_fill),  64'(sb[0].fill));
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    send(4'b0011, 1'b0, 32'h0000BEEF);

    send(4'b0000, 1'b1, 32'h0);
    send(4'b0111, 1'b0, 32'h00112233);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(m_valid), 64'd0);
    chk("mid_rst_fill",  64'(m_fill),  64'd0);
    sb.delete();
    off_m = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(4'b1000, 1'b0, 32'h77000000);
    send(4'b0000, 1'b0, 32'h0);
`ifdef BANYAN_DST_GEN_DROP_EMPTY_EN
    repeat (2) begin
      @(negedge clk);
      chk("drop_valid", 64'(m_valid), 64'd0);
    end
    @(posedge clk);
    #1;
`endif

    for (int t = 0; t < 30; t++) begin
      send(4'($urandom_range(0, 15)),
           ($urandom_range(0, 5) == 0),
           $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
